data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised next-generation data memory for the P_Risc core, with a valid/ready request/response interface.
- Supports byte, halfword and word stores through byte enables; loads are sign- or zero-extended.
- Reports misaligned, out-of-range and reserved-size accesses as errors.
- After reset, clears all storage with a sequential init sweep before it accepts any request.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; power of two, minimum 4
ADDR_W, 32, width of the byte address
ERRCNT_W, 8, width of the saturating error counter

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST_N  input  1  synchronous, active-low reset
REQ_VALID  input  1  request present
REQ_READY  output  1  controller can accept a request this cycle
REQ_WE  input  1  1 = store, 0 = load
REQ_SIZE  input  2  00 byte, 01 half, 10 word, 11 reserved
REQ_UNSIGNED  input  1  load zero-extends when 1
REQ_ADDR  input  ADDR_W  byte address, little-endian
REQ_WDATA  input  32  store data, right-justified
RSP_VALID  output  1  response present
RSP_READY  input  1  consumer accepts the response
RSP_RDATA  output  32  extended load data; 0 for stores and errors
RSP_ERR  output  1  the access was rejected
INIT_DONE  output  1  memory clear complete
ERR_COUNT  output  ERRCNT_W  saturating count of error responses

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - Enters INIT with the pointer at 0.
  - REQ_READY=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, INIT_DONE=0, ERR_COUNT=0.
  - A pending response is discarded; reset in any state restarts INIT.
- INIT:
  - Writes 0 to word[ptr] each cycle, ptr increments.
  - After DEPTH_WORDS cycles (ptr=DEPTH_WORDS-1 written): INIT_DONE=1, go to RUN.
  - Requests are ignored during INIT.
- RUN:
  - REQ_READY = !RSP_VALID | RSP_READY. This is a combinational path from RSP_READY.
  - A request is accepted on an edge where REQ_VALID & REQ_READY.
  - Response appears in the cycle after acceptance (1-cycle latency). RSP_VALID=1 from then on.
  - RSP_RDATA and RSP_ERR are held stable until RSP_VALID & RSP_READY.
  - Back-to-back: a response consumed in the same cycle a new request is accepted → RSP_VALID stays 1 with the new data. Full throughput is 1 request per cycle.
  - Response consumed with no new request → RSP_VALID=0 on the next edge.
- Error conditions (any one makes the request an error):
  - REQ_SIZE=11.
  - Half access with ADDR[0]=1.
  - Word access with ADDR[1:0]≠0.
  - Word index ADDR[ADDR_W-1:2] ≥ DEPTH_WORDS; the full address is compared, so there is no aliasing.
- Error response: no memory write, RSP_RDATA=0, RSP_ERR=1, ERR_COUNT+1, saturating at all-ones.
- Store:
  - Byte writes WDATA[7:0] into lane ADDR[1:0].
  - Half writes WDATA[15:0] into lanes {ADDR[1],0}+1:0.
  - Word writes all 4 lanes.
  - Other lanes are unchanged. Response is RSP_RDATA=0, RSP_ERR=0.
- Load:
  - The selected lane(s) are right-justified.
  - Sign-extended from bit 7 or 15 unless REQ_UNSIGNED=1 (then zero-extended).
  - REQ_UNSIGNED is ignored for word loads.
- Read timing:
  - A load reads the array state as of the acceptance edge, i.e. before any write accepted at that same edge.
  - A store followed by a load to the same word on the next accepted request returns the new data.
- Address fields are captured at acceptance; later input changes do not affect the response.

Decomposition:
- Package dmem_pkg:
  - SIZE_B/SIZE_H/SIZE_W/SIZE_RSV encodings.
  - State enum {ST_INIT, ST_RUN}.
  - Function load_extend(word, lane, size, unsigned).
  - Function store_be(size, lane) returning a 4-bit byte enable.
- Sub-module dmem_ram_be: synchronous-write/synchronous-read RAM, DEPTH_WORDS×32, with a 4-bit byte-enable write port.
  - Read data registered at the request edge.
  - The controller muxes in the INIT clear writes.

Test Plan:
- Init: reset low 2 cycles, release → INIT_DONE rises after exactly 64 cycles; REQ_READY=0 throughout; load word @0x3C → 0x00000000, ERR=0.
- Sub-word store/load:
  - SW 0x11223344 @0x10, then SB 0xAA @0x13 → LW @0x10 = 0xAA223344.
  - LB @0x13 = 0xFFFFFFAA; LBU @0x13 = 0x000000AA; LH @0x12 = 0xFFFFAA22.
- Errors: SW @0x102 (misaligned), LW @0x100 (out of range), LH @0x01, SIZE=11 → each RSP_ERR=1, RDATA=0, no write, ERR_COUNT=4.
- Backpressure: hold RSP_READY=0 after a load → REQ_READY=0, RSP held 5 cycles unchanged; then RSP_READY=1 with a queued request → new response the next cycle, no gap.
- Throughput: 16 back-to-back SW @0x00..0x3C, RSP_READY=1 → 16 responses in 16 consecutive cycles; readback matches.
- Reset mid-response: reset with RSP_VALID=1 → RSP_VALID=0; full INIT repeats; prior data reads 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the P_Risc data memory.
//   - SIZE_* : access-size encodings carried on REQ_SIZE
//   - state_t: controller state (INIT clear sweep, RUN)
//   - load_extend : lane select + sign/zero extension for loads
//   - store_be    : byte-enable pattern for a store
//   - store_lanes : replicates right-justified store data onto every lane
package dmem_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Right-justify the addressed byte/half of a stored word and extend it.
  // Word loads ignore is_unsigned.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  r = is_unsigned ? {24'h0, b} : 32'(b);
      SIZE_H:  r = is_unsigned ? {16'h0, h} : 32'(h);
      default: r = word;
    endcase
    return r;
  endfunction

  // Byte enables for a store; the reserved size writes nothing.
  function automatic logic [3:0] store_be(input logic [1:0] size,
                                          input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << lane;
      SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicating the store data lets the byte enables alone pick the lane.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] r;
    case (size)
      SIZE_B:  r = {4{wdata[7:0]}};
      SIZE_H:  r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// dmem_ram_be: DEPTH_WORDS x 32 single-clock RAM with byte-enable write port
// and registered read port.
//   CLK   : clock
//   WE    : write enable, BE selects the byte lanes written at WADDR
//   BE    : 4-bit byte enable (bit n covers WDATA[8n+7:8n])
//   WADDR : write word index
//   WDATA : write data
//   RE    : read enable; RDATA updates only when RE is high
//   RADDR : read word index
//   RDATA : read data, holds its value between reads
// A read and a write to the same word at the same edge return the old data.
module dmem_ram_be #(
  parameter int DEPTH_WORDS = 64,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             CLK,
  input  logic             WE,
  input  logic [3:0]       BE,
  input  logic [IDX_W-1:0] WADDR,
  input  logic [31:0]      WDATA,
  input  logic             RE,
  input  logic [IDX_W-1:0] RADDR,
  output logic [31:0]      RDATA
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (WE) begin
      for (int b = 0; b < 4; b++) begin
        if (BE[b]) mem[WADDR][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
    if (RE) RDATA <= mem[RADDR];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: P_Risc data memory with valid/ready request and response.
//   CLK, RST_N    : clock, synchronous active-low reset (restarts the clear)
//   REQ_VALID/REQ_READY : request handshake
//   REQ_WE        : 1 store, 0 load
//   REQ_SIZE      : 00 byte, 01 half, 10 word, 11 reserved (error)
//   REQ_UNSIGNED  : zero-extend byte/half loads
//   REQ_ADDR      : little-endian byte address
//   REQ_WDATA     : right-justified store data
//   RSP_VALID/RSP_READY : response handshake, one cycle after acceptance
//   RSP_RDATA     : extended load data, 0 for stores and errors
//   RSP_ERR       : request was rejected (misaligned, out of range, reserved)
//   INIT_DONE     : clear sweep finished, requests now accepted
//   ERR_COUNT     : saturating number of error responses
// ADDR_W must exceed log2(DEPTH_WORDS)+2 so the out-of-range field exists.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32,
  parameter int ERRCNT_W    = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WE,
  input  logic [1:0]          REQ_SIZE,
  input  logic                REQ_UNSIGNED,
  input  logic [ADDR_W-1:0]   REQ_ADDR,
  input  logic [31:0]         REQ_WDATA,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [31:0]         RSP_RDATA,
  output logic                RSP_ERR,
  output logic                INIT_DONE,
  output logic [ERRCNT_W-1:0] ERR_COUNT
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                state;
  logic [IDX_W-1:0]      init_ptr;
  logic                  init_done_r;
  logic [ERRCNT_W-1:0]   err_cnt;

  logic                  vld_p1;
  logic                  err_p1;
  logic                  load_p1;
  logic [1:0]            lane_p1;
  logic [1:0]            size_p1;
  logic                  uns_p1;

  logic                  ram_we;
  logic [3:0]            ram_be;
  logic [IDX_W-1:0]      ram_waddr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  // ---- p0: request decode and acceptance ----
  logic                  accept_p0;
  logic                  rsv_p0;
  logic                  mis_p0;
  logic                  oor_p0;
  logic                  err_p0;
  logic                  store_p0;
  logic                  load_p0;
  logic [1:0]            lane_p0;
  logic [IDX_W-1:0]      idx_p0;

  assign lane_p0 = REQ_ADDR[1:0];
  assign idx_p0  = REQ_ADDR[IDX_W+1:2];
  assign rsv_p0  = (REQ_SIZE == SIZE_RSV);
  assign mis_p0  = ((REQ_SIZE == SIZE_H) && REQ_ADDR[0]) ||
                   ((REQ_SIZE == SIZE_W) && (REQ_ADDR[1:0] != 2'b00));
  // Any set bit above the word index is out of range; no aliasing.
  assign oor_p0  = |REQ_ADDR[ADDR_W-1:IDX_W+2];
  assign err_p0  = rsv_p0 | mis_p0 | oor_p0;

  assign REQ_READY = (state == ST_RUN) && (!vld_p1 || RSP_READY);
  assign accept_p0 = REQ_VALID && REQ_READY;
  assign store_p0  = accept_p0 && REQ_WE && !err_p0;
  assign load_p0   = accept_p0 && !REQ_WE && !err_p0;

  // The clear sweep owns the write port during INIT.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_waddr = idx_p0;
    ram_wdata = store_lanes(REQ_SIZE, REQ_WDATA);
    if (state == ST_INIT) begin
      ram_we    = 1'b1;
      ram_be    = 4'b1111;
      ram_waddr = init_ptr;
      ram_wdata = 32'h0;
    end else begin
      ram_we    = store_p0;
      ram_be    = store_be(REQ_SIZE, lane_p0);
    end
  end

  dmem_ram_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .CLK   (CLK),
    .WE    (ram_we),
    .BE    (ram_be),
    .WADDR (ram_waddr),
    .WDATA (ram_wdata),
    .RE    (load_p0),
    .RADDR (idx_p0),
    .RDATA (ram_rdata)
  );

  // ---- p1: response register ----
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_INIT;
      init_ptr    <= '0;
      init_done_r <= 1'b0;
      err_cnt     <= '0;
      vld_p1      <= 1'b0;
      err_p1      <= 1'b0;
      load_p1     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == IDX_W'(DEPTH_WORDS - 1)) begin
            state       <= ST_RUN;
            init_done_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_p0) begin
            vld_p1  <= 1'b1;
            err_p1  <= err_p0;
            load_p1 <= load_p0;
            if (err_p0) err_cnt <= sat_inc(err_cnt);
          end else if (vld_p1 && RSP_READY) begin
            vld_p1 <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Lane/size qualifiers only matter while load_p1 is set, so no reset.
  always_ff @(posedge CLK) begin
    if (accept_p0) begin
      lane_p1 <= lane_p0;
      size_p1 <= REQ_SIZE;
      uns_p1  <= REQ_UNSIGNED;
    end
  end

  assign RSP_VALID = vld_p1;
  assign RSP_ERR   = err_p1;
  assign RSP_RDATA = load_p1 ? load_extend(ram_rdata, lane_p1, size_p1, uns_p1) : 32'h0;
  assign INIT_DONE = init_done_r;
  assign ERR_COUNT = err_cnt;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed vectors with literal expectations,
// plus a behavioural memory model checked against the DUT every cycle.
module tb_data_mem_ctrl;

  localparam int DEPTH = 64;

  logic        CLK          = 1'b0;
  logic        RST_N        = 1'b0;
  logic        REQ_VALID    = 1'b0;
  logic        REQ_WE       = 1'b0;
  logic [1:0]  REQ_SIZE     = 2'b00;
  logic        REQ_UNSIGNED = 1'b0;
  logic [31:0] REQ_ADDR     = 32'h0;
  logic [31:0] REQ_WDATA    = 32'h0;
  logic        RSP_READY    = 1'b0;
  logic        REQ_READY;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        INIT_DONE;
  logic [7:0]  ERR_COUNT;

  data_mem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W     (32),
    .ERRCNT_W   (8)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_WE       (REQ_WE),
    .REQ_SIZE     (REQ_SIZE),
    .REQ_UNSIGNED (REQ_UNSIGNED),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_WDATA    (REQ_WDATA),
    .RSP_VALID    (RSP_VALID),
    .RSP_READY    (RSP_READY),
    .RSP_RDATA    (RSP_RDATA),
    .RSP_ERR      (RSP_ERR),
    .INIT_DONE    (INIT_DONE),
    .ERR_COUNT    (ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [31:0] m_mem [DEPTH];
  rsp_t        m_q[$];
  int          m_init_cnt  = 0;
  int          m_errcnt    = 0;
  bit          m_armed     = 1'b0;
  bit          m_after_rst = 1'b0;

  function automatic rsp_t model_access(input logic we, input logic [1:0] sz,
                                        input logic uns, input logic [31:0] addr,
                                        input logic [31:0] wd);
    rsp_t        r;
    int          idx;
    int          lane;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    r    = '0;
    lane = int'(addr[1:0]);
    if (sz == 2'b11 || (sz == 2'b01 && addr[0]) ||
        (sz == 2'b10 && addr[1:0] != 2'b00) || addr[31:2] >= 30'(DEPTH)) begin
      r.err = 1'b1;
      if (m_errcnt < 255) m_errcnt++;
      return r;
    end
    idx = int'(addr[31:2]);
    w   = m_mem[idx];
    if (we) begin
      if (sz == 2'b00)      w[8*lane +: 8]              = wd[7:0];
      else if (sz == 2'b01) w[16*int'(addr[1]) +: 16]   = wd[15:0];
      else                  w                           = wd;
      m_mem[idx] = w;
    end else begin
      b = w[8*lane +: 8];
      h = w[16*int'(addr[1]) +: 16];
      if (sz == 2'b00)      r.data = uns ? {24'h0, b} : {{24{b[7]}}, b};
      else if (sz == 2'b01) r.data = uns ? {16'h0, h} : {{16{h[15]}}, h};
      else                  r.data = w;
    end
    return r;
  endfunction

  // Outputs are checked at the falling edge; the model then advances by
  // what the coming rising edge will do with the inputs now stable.
  always @(negedge CLK) begin : model_cmp
    bit   exp_ready;
    rsp_t r;
    exp_ready = (m_init_cnt == DEPTH) && (m_q.size() == 0 || RSP_READY);
    if (m_armed) begin
      chk("m_req_ready", 32'(REQ_READY), 32'(exp_ready));
      chk("m_init_done", 32'(INIT_DONE), 32'(m_init_cnt == DEPTH));
      chk("m_err_count", 32'(ERR_COUNT), 32'(m_errcnt));
      chk("m_rsp_valid", 32'(RSP_VALID), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("m_rsp_rdata", RSP_RDATA, m_q[0].data);
        chk("m_rsp_err", 32'(RSP_ERR), 32'(m_q[0].err));
      end else if (m_after_rst) begin
        chk("m_rst_rdata", RSP_RDATA, 32'h0);
        chk("m_rst_err", 32'(RSP_ERR), 32'h0);
      end
    end
    if (!RST_N) begin
      m_armed     = 1'b1;
      m_after_rst = 1'b1;
      m_q.delete();
      m_errcnt    = 0;
      m_init_cnt  = 0;
      foreach (m_mem[i]) m_mem[i] = 32'h0;
    end else if (m_armed) begin
      if (m_init_cnt < DEPTH) begin
        m_init_cnt++;
      end else begin
        if (m_q.size() != 0 && RSP_READY) void'(m_q.pop_front());
        if (REQ_VALID && exp_ready) begin
          r = model_access(REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA);
          m_q.push_back(r);
          m_after_rst = 1'b0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!INIT_DONE && n < 200) begin
      chk({nm, "_ready_low"}, 32'(REQ_READY), 32'h0);
      tick();
      n++;
    end
    chk({nm, "_cycles"}, 32'(n), 32'd64);
  endtask

  task automatic xact(input string nm, input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    n            = 0;
    REQ_VALID    = 1'b1;
    REQ_WE       = we;
    REQ_SIZE     = sz;
    REQ_UNSIGNED = uns;
    REQ_ADDR     = addr;
    REQ_WDATA    = wd;
    RSP_READY    = 1'b1;
    while (!REQ_READY && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_accept: REQ_READY never rose within 50 cycles", nm);
      REQ_VALID = 1'b0;
      return;
    end
    tick();
    // Scramble the request fields: the response must use the captured ones.
    REQ_VALID = 1'b0;
    REQ_ADDR  = 32'hFFFF_FFFC;
    REQ_SIZE  = 2'b11;
    REQ_WDATA = 32'hDEAD_BEEF;
    chk({nm, "_vld"}, 32'(RSP_VALID), 32'h1);
    chk({nm, "_data"}, RSP_RDATA, exp_d);
    chk({nm, "_err"}, 32'(RSP_ERR), 32'(exp_e));
    tick();
  endtask

  initial begin : global_timeout
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    RST_N = 1'b0;
    tick();
    tick();
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
    chk("rst_init_done", 32'(INIT_DONE), 32'h0);
    chk("rst_err_count", 32'(ERR_COUNT), 32'h0);
    chk("rst_req_ready", 32'(REQ_READY), 32'h0);
    RST_N = 1'b1;
    wait_init("init1");
    xact("lw_3c_after_init", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0);

    // Sub-word stores and extended loads.
    xact("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
    xact("sb_13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AA, 32'h0, 1'b0);
    xact("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hAA22_3344, 1'b0);
    xact("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFAA, 1'b0);
    xact("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_00AA, 1'b0);
    xact("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_AA22, 1'b0);
    xact("lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000_AA22, 1'b0);
    xact("lb_10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0000_0044, 1'b0);
    xact("lwu_10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hAA22_3344, 1'b0);

    // Error responses.
    xact("sw_102_err", 1'b1, 2'b10, 1'b0, 32'h102, 32'h5555_5555, 32'h0, 1'b1);
    xact("lw_100_err", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    xact("lh_01_err", 1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 32'h0, 1'b1);
    xact("rsv_err", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    chk("err_count_4", 32'(ERR_COUNT), 32'd4);
    xact("rsv_store_err", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0000_0077, 32'h0, 1'b1);
    xact("sw_110_alias_err", 1'b1, 2'b10, 1'b0, 32'h110, 32'h9999_9999, 32'h0, 1'b1);
    chk("err_count_6", 32'(ERR_COUNT), 32'd6);
    xact("lw_10_unchanged", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hAA22_3344, 1'b0);

    // Backpressure.
    RSP_READY = 1'b0;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b0;
    REQ_SIZE  = 2'b10;
    REQ_ADDR  = 32'h10;
    chk("bp_ready_idle", 32'(REQ_READY), 32'h1);
    tick();
    REQ_SIZE     = 2'b01;
    REQ_ADDR     = 32'h12;
    REQ_UNSIGNED = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", 32'(REQ_READY), 32'h0);
      chk("bp_rsp_valid", 32'(RSP_VALID), 32'h1);
      chk("bp_rsp_data", RSP_RDATA, 32'hAA22_3344);
      tick();
    end
    RSP_READY = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(REQ_READY), 32'h1);
    tick();
    REQ_VALID = 1'b0;
    chk("bp_next_valid", 32'(RSP_VALID), 32'h1);
    chk("bp_next_data", RSP_RDATA, 32'hFFFF_AA22);
    tick();
    chk("bp_drained", 32'(RSP_VALID), 32'h0);

    // Throughput: one store per cycle.
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      REQ_VALID = 1'b1;
      REQ_WE    = 1'b1;
      REQ_SIZE  = 2'b10;
      REQ_ADDR  = 32'(4 * i);
      REQ_WDATA = 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
      chk("tp_req_ready", 32'(REQ_READY), 32'h1);
      tick();
      if (RSP_VALID) cnt++;
    end
    REQ_VALID = 1'b0;
    chk("tp_resp_count", 32'(cnt), 32'd16);
    tick();
    chk("tp_idle_after", 32'(RSP_VALID), 32'h0);
    for (int i = 0; i < 16; i++) begin
      xact("tp_readback", 1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0,
           32'hC0DE_0000 + 32'(i) * 32'h0000_1111, 1'b0);
    end

    // Reset while a response is pending.
    RSP_READY = 1'b0;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b0;
    REQ_SIZE  = 2'b10;
    REQ_ADDR  = 32'h0;
    tick();
    REQ_VALID = 1'b0;
    chk("mid_rsp_valid", 32'(RSP_VALID), 32'h1);
    chk("mid_rsp_data", RSP_RDATA, 32'hC0DE_0000);
    RST_N = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(RSP_VALID), 32'h0);
    chk("mid_rst_rdata", RSP_RDATA, 32'h0);
    chk("mid_rst_err", 32'(RSP_ERR), 32'h0);
    chk("mid_rst_errcnt", 32'(ERR_COUNT), 32'h0);
    chk("mid_rst_done", 32'(INIT_DONE), 32'h0);
    tick();
    RST_N     = 1'b1;
    RSP_READY = 1'b1;
    wait_init("init2");
    xact("post_rst_lw_00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    xact("post_rst_lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    xact("post_rst_lw_3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);

    // Error counter saturation.
    RSP_READY = 1'b1;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b0;
    REQ_SIZE  = 2'b11;
    REQ_ADDR  = 32'h0;
    repeat (260) tick();
    REQ_VALID = 1'b0;
    tick();
    chk("errcnt_saturated", 32'(ERR_COUNT), 32'd255);
    xact("errcnt_sat_hold", 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1);
    chk("errcnt_still_sat", 32'(ERR_COUNT), 32'd255);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
